// File: rtl/ans_divergence_logger.sv
// Flags disagreement between three result lanes and logs divergent samples into a FWFT FIFO.
// Optional macro ANS_LOG_TIMESTAMP_EN prepends a 16-bit capture-cycle stamp to each record.
module ans_divergence_logger #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
`ifdef ANS_LOG_TIMESTAMP_EN
  localparam int TS_W = 16,
`else
  localparam int TS_W = 0,
`endif
  localparam int REC_W = TS_W + 3 + 3 * WIDTH,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ans1,
  input  logic [WIDTH-1:0] ans2,
  input  logic [WIDTH-1:0] ans3,
  input  logic             rec_ready,
  output logic             rec_valid,
  output logic [REC_W-1:0] rec_data,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             overflow,
  output logic             running
);

  localparam int PW = LVL_W - 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t           r_state;
  logic             r_running;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cnt;
  logic [LVL_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_rd_ptr;
  logic [REC_W-1:0] r_mem [DEPTH];

  logic             r_s1_valid;
  logic [2:0]       r_s1_mask;
  logic [WIDTH-1:0] r_s1_a1;
  logic [WIDTH-1:0] r_s1_a2;
  logic [WIDTH-1:0] r_s1_a3;

  logic [2:0]       w_mask;
  logic [REC_W-1:0] w_rec;
  logic [LVL_W-1:0] w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_req;
  logic             w_push;
  logic             w_drop;

  assign w_mask     = {ans1 != ans3, ans2 != ans3, ans1 != ans2};
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == FULL_LVL);
  assign w_pop      = !w_empty && rec_ready;
  assign w_push_req = r_s1_valid && (r_s1_mask != 3'b000) && (r_state == S_RUN);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

`ifdef ANS_LOG_TIMESTAMP_EN
  logic [15:0] r_ts;
  logic [15:0] r_s1_ts;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_ts    <= '0;
      r_s1_ts <= '0;
    end else begin
      r_ts    <= r_ts + 16'd1;
      r_s1_ts <= r_ts;
    end
  end

  assign w_rec = {r_s1_ts, r_s1_mask, r_s1_a1, r_s1_a2, r_s1_a3};
`else
  assign w_rec = {r_s1_mask, r_s1_a1, r_s1_a2, r_s1_a3};
`endif

  // Stage 1: clear kills the in-flight sample so nothing is logged after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mask  <= '0;
      r_s1_a1    <= '0;
      r_s1_a2    <= '0;
      r_s1_a3    <= '0;
    end else begin
      r_s1_valid <= in_valid && !clear;
      r_s1_mask  <= w_mask;
      r_s1_a1    <= ans1;
      r_s1_a2    <= ans2;
      r_s1_a3    <= ans3;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PW-1:0]] <= w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state    <= S_IDLE;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Dropped samples still count as divergent.
      if (w_push_req && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_drop) begin
            r_state   <= S_HALT;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign rec_valid    = !w_empty;
  assign rec_data     = w_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];
  assign level        = w_level;
  assign mismatch_cnt = r_cnt;
  assign overflow     = r_overflow;
  assign running      = r_running;

endmodule

// File: tb/tb_ans_divergence_logger.sv
// Scoreboard bench for ans_divergence_logger: a cycle-level behavioural model predicts records,
// a negedge monitor pops them on each handshake and compares.
`timescale 1ns/1ps
module tb_ans_divergence_logger;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
`ifdef ANS_LOG_TIMESTAMP_EN
  localparam int TS_W = 16;
`else
  localparam int TS_W = 0;
`endif
  localparam int REC_W = TS_W + 3 + 3 * WIDTH;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start, clear, in_valid, rec_ready;
  logic [WIDTH-1:0] ans1, ans2, ans3;
  logic             rec_valid;
  logic [REC_W-1:0] rec_data;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             overflow, running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ans_divergence_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .in_valid(in_valid),
    .ans1(ans1), .ans2(ans2), .ans3(ans3), .rec_ready(rec_ready),
    .rec_valid(rec_valid), .rec_data(rec_data), .level(level),
    .mismatch_cnt(mismatch_cnt), .overflow(overflow), .running(running)
  );

  // Behavioural reference state
  typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
  mstate_t          m_state = M_IDLE;
  int               m_level = 0;
  int               m_cnt = 0;
  bit               m_ovf = 1'b0;
  bit               s1_v = 1'b0;
  logic [WIDTH-1:0] s1_a1, s1_a2, s1_a3;
  int               m_ts = 0;
  int               s1_ts = 0;
  logic [REC_W-1:0] exp_q[$];
  bit               chk_en = 1'b0;

`ifdef ANS_LOG_TIMESTAMP_EN
  bit          sat_phase = 1'b0;
  bit          have_prev = 1'b0;
  logic [15:0] prev_ts;
`endif

  function automatic logic [REC_W-1:0] make_rec(input int ts, input logic [3:0] a, b, c);
    logic [2:0]  m;
    logic [30:0] full;
    m[0] = (a != b);
    m[1] = (b != c);
    m[2] = (a != c);
    full = {ts[15:0], m, a, b, c};
    return full[REC_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model advances on each rising edge using the inputs held since the previous edge.
  always @(posedge clk) begin
    mstate_t old;
    bit      pop, req;
    int      lvl0;
    if (reset || clear) begin
      m_state = M_IDLE; m_level = 0; m_cnt = 0; m_ovf = 1'b0;
      s1_v = 1'b0; m_ts = 0; exp_q.delete();
    end else begin
      old  = m_state;
      lvl0 = m_level;
      pop  = (lvl0 > 0) && rec_ready;
      req  = s1_v && !((s1_a1 == s1_a2) && (s1_a2 == s1_a3)) && (old == M_RUN);
      if (pop) m_level--;
      if (req) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (lvl0 < DEPTH || pop) begin
          exp_q.push_back(make_rec(s1_ts, s1_a1, s1_a2, s1_a3));
          m_level++;
        end else begin
          m_ovf = 1'b1;
          m_state = M_HALT;
        end
      end
      if (start && old != M_RUN) m_state = M_RUN;
      s1_v  = in_valid;
      s1_a1 = ans1; s1_a2 = ans2; s1_a3 = ans3;
      s1_ts = m_ts;
      m_ts  = (m_ts + 1) % 65536;
    end
  end

  // Status checker
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rec_valid", rec_valid, m_level > 0);
      chk("level", level, m_level);
      chk("mismatch_cnt", mismatch_cnt, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("running", running, m_state == M_RUN);
      if (!rec_valid) chk("rec_data_empty", rec_data, 0);
    end
  end

  // Scoreboard monitor: one record leaves the DUT on every handshake.
  always @(negedge clk) begin
    logic [REC_W-1:0] e;
    if (chk_en && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rec_pop: got record %0h expected no record (t=%0t)", rec_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rec_data", rec_data, e);
`ifdef ANS_LOG_TIMESTAMP_EN
        if (sat_phase) begin
          if (have_prev) chk("ts_step", rec_data[REC_W-1 -: 16], prev_ts + 16'd1);
          prev_ts   = rec_data[REC_W-1 -: 16];
          have_prev = 1'b1;
        end
`endif
      end
    end
  end

  task automatic drive(input bit st, cl, v, input logic [3:0] a, b, c, input bit rdy);
    start = st; clear = cl; in_valid = v; ans1 = a; ans2 = b; ans3 = c; rec_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, rdy);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    ans1 = '0; ans2 = '0; ans3 = '0; rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_rec_data", rec_data, 0);
    chk("rst_level", level, 0);
    chk("rst_running", running, 0);
    reset = 1'b0;

    // Agreeing lanes never log
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (5) drive(0, 0, 1, 4, 4, 4, 0);
    idle(2, 0);
    chk("eq_rec_valid", rec_valid, 0);
    chk("eq_cnt", mismatch_cnt, 0);
    chk("eq_running", running, 1);

    // Single divergent sample, two-cycle latency
    drive(0, 0, 1, 4, 2, 4, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("one_rec_valid", rec_valid, 1);
    chk("one_rec_data", rec_data[14:0], 15'h3424);
    chk("one_level", level, 1);
    chk("one_cnt", mismatch_cnt, 1);

    // Overfill: ninth record dropped, halt
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (9) drive(0, 0, 1, 1, 0, 0, 0);
    idle(2, 0);
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_running", running, 0);
    chk("ovf_cnt", mismatch_cnt, 9);
    chk("ovf_head", rec_data[14:0], 15'h5100);

    // Restart with a divergent sample in flight, then clear+start together
    drive(1, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("clr_running", running, 0);
    chk("clr_level", level, 0);
    chk("clr_cnt", mismatch_cnt, 0);
    chk("clr_ovf", overflow, 0);
    idle(3, 1);
    chk("clr_no_rec", rec_valid, 0);

    // Full FIFO: simultaneous push and pop loses nothing
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (8) drive(0, 0, 1, 1, 0, 0, 0);
    idle(2, 0);
    chk("full_level", level, 8);
    drive(0, 0, 1, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1, 0);
    chk("pp_level", level, 8);
    chk("pp_ovf", overflow, 0);
    chk("pp_running", running, 1);
    idle(12, 1);
    chk("drain_level", level, 0);

    // Randomised traffic with occasional start/clear/reset
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
            $urandom_range(0, 3) != 0);
    end
    reset = 1'b0;

    // Counter saturation with continuous draining
    drive(0, 1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
`ifdef ANS_LOG_TIMESTAMP_EN
    sat_phase = 1'b1;
`endif
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 1, 4'($urandom_range(1, 15)), 4'd0, 4'($urandom_range(0, 15)), 1);
    end
    idle(4, 1);
`ifdef ANS_LOG_TIMESTAMP_EN
    sat_phase = 1'b0;
`endif
    chk("sat_cnt", mismatch_cnt, CNT_MAX);
    chk("sat_ovf", overflow, 0);
    chk("sat_level", level, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
